// File: rtl/id_ex_pipe_pkg.sv
// Shared widths, encodings and the ID->EX field bundle for the ID->EX pipeline register.
// The bundle carries every field that travels from decode to execute, except the valid bit.
package id_ex_pipe_pkg;

   localparam int XLEN = 32;
   localparam int RA_W = 5;

   localparam logic [1:0] RES_LOAD  = 2'b01;

   localparam logic [1:0] JT_NONE   = 2'b00;
   localparam logic [1:0] JT_JAL    = 2'b01;
   localparam logic [1:0] JT_JALR   = 2'b10;
   localparam logic [1:0] JT_BRANCH = 2'b11;

   localparam logic [15:0] BUBBLE_CNT_MAX = 16'hFFFF;

   typedef struct packed {
      logic [2:0]      ex;
      logic [1:0]      jump_t;
      logic            slt;
      logic            lui;
      logic            alu_src;
      logic            mem_write;
      logic            reg_write;
      logic [1:0]      result_src;
      logic [RA_W-1:0] rs1;
      logic [RA_W-1:0] rs2;
      logic [RA_W-1:0] rd;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
   } id_ex_fields_t;

   // An invalid slot must not be able to write state or redirect the PC.
   function automatic id_ex_fields_t kill_side_effects(input id_ex_fields_t f);
      id_ex_fields_t r;
      r           = f;
      r.reg_write = 1'b0;
      r.mem_write = 1'b0;
      r.jump_t    = JT_NONE;
      return r;
   endfunction

endpackage

// File: rtl/id_ex_pipe_hazard_detect.sv
// Combinational load-use detection plus the fetch/decode stall and flush controls.
// A redirect overrides the stall so the refetch from the new PC can proceed.
module hazard_detect
   import id_ex_pipe_pkg::*;
(
   input  logic            redirect,
   input  logic            ex_valid,
   input  logic            ex_reg_write,
   input  logic [1:0]      ex_result_src,
   input  logic [RA_W-1:0] ex_rd,
   input  logic            id_valid,
   input  logic [RA_W-1:0] id_rs1,
   input  logic [RA_W-1:0] id_rs2,
   output logic            lu,
   output logic            stall_fd,
   output logic            flush_d
);

   logic ex_is_load;
   logic rs_match;

   always_comb begin
      ex_is_load = ex_valid && ex_reg_write && (ex_result_src == RES_LOAD) && (ex_rd != '0);
      rs_match   = (ex_rd == id_rs1) || (ex_rd == id_rs2);
      lu         = ex_is_load && id_valid && rs_match;
      stall_fd   = lu && !redirect;
      flush_d    = redirect;
   end

endmodule

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register with load-use bubble insertion, redirect squash
// and a saturating count of inserted bubbles.
module id_ex_pipe
   import id_ex_pipe_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect,
   input  logic            id_valid,
   input  logic [2:0]      id_ex,
   input  logic [1:0]      id_jump_t,
   input  logic            id_slt,
   input  logic            id_lui,
   input  logic            id_alu_src,
   input  logic            id_mem_write,
   input  logic            id_reg_write,
   input  logic [1:0]      id_result_src,
   input  logic [RA_W-1:0] id_rs1,
   input  logic [RA_W-1:0] id_rs2,
   input  logic [RA_W-1:0] id_rd,
   input  logic [XLEN-1:0] id_rd1,
   input  logic [XLEN-1:0] id_rd2,
   input  logic [XLEN-1:0] id_imm,
   input  logic [XLEN-1:0] id_pc,
   output logic            ex_valid,
   output logic [2:0]      ex_ex,
   output logic [1:0]      ex_jump_t,
   output logic            ex_slt,
   output logic            ex_lui,
   output logic            ex_alu_src,
   output logic            ex_mem_write,
   output logic            ex_reg_write,
   output logic [1:0]      ex_result_src,
   output logic [RA_W-1:0] ex_rs1,
   output logic [RA_W-1:0] ex_rs2,
   output logic [RA_W-1:0] ex_rd,
   output logic [XLEN-1:0] ex_rd1,
   output logic [XLEN-1:0] ex_rd2,
   output logic [XLEN-1:0] ex_imm,
   output logic [XLEN-1:0] ex_pc,
   output logic            stall_fd,
   output logic            flush_d,
   output logic [15:0]     bubble_cnt
);

   id_ex_fields_t id_fields;
   id_ex_fields_t ex_d, ex_q;
   logic          ex_valid_d, ex_valid_q;
   logic [15:0]   bubble_cnt_d, bubble_cnt_q;
   logic          lu;

   always_comb begin
      id_fields.ex         = id_ex;
      id_fields.jump_t     = id_jump_t;
      id_fields.slt        = id_slt;
      id_fields.lui        = id_lui;
      id_fields.alu_src    = id_alu_src;
      id_fields.mem_write  = id_mem_write;
      id_fields.reg_write  = id_reg_write;
      id_fields.result_src = id_result_src;
      id_fields.rs1        = id_rs1;
      id_fields.rs2        = id_rs2;
      id_fields.rd         = id_rd;
      id_fields.rd1        = id_rd1;
      id_fields.rd2        = id_rd2;
      id_fields.imm        = id_imm;
      id_fields.pc         = id_pc;
   end

   hazard_detect u_hazard_detect (
      .redirect      (redirect),
      .ex_valid      (ex_valid_q),
      .ex_reg_write  (ex_q.reg_write),
      .ex_result_src (ex_q.result_src),
      .ex_rd         (ex_q.rd),
      .id_valid      (id_valid),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .lu            (lu),
      .stall_fd      (stall_fd),
      .flush_d       (flush_d)
   );

   // Redirect and load-use both turn the slot into an all-zero bubble and count once.
   always_comb begin
      ex_d         = id_fields;
      ex_valid_d   = id_valid;
      bubble_cnt_d = bubble_cnt_q;
      if (!id_valid) begin
         ex_d = kill_side_effects(id_fields);
      end
      if (redirect || lu) begin
         ex_d       = '0;
         ex_valid_d = 1'b0;
         if (bubble_cnt_q != BUBBLE_CNT_MAX) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q         <= '0;
         ex_valid_q   <= 1'b0;
         bubble_cnt_q <= '0;
      end else begin
         ex_q         <= ex_d;
         ex_valid_q   <= ex_valid_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   always_comb begin
      ex_valid      = ex_valid_q;
      ex_ex         = ex_q.ex;
      ex_jump_t     = ex_q.jump_t;
      ex_slt        = ex_q.slt;
      ex_lui        = ex_q.lui;
      ex_alu_src    = ex_q.alu_src;
      ex_mem_write  = ex_q.mem_write;
      ex_reg_write  = ex_q.reg_write;
      ex_result_src = ex_q.result_src;
      ex_rs1        = ex_q.rs1;
      ex_rs2        = ex_q.rs2;
      ex_rd         = ex_q.rd;
      ex_rd1        = ex_q.rd1;
      ex_rd2        = ex_q.rd2;
      ex_imm        = ex_q.imm;
      ex_pc         = ex_q.pc;
      bubble_cnt    = bubble_cnt_q;
   end

endmodule
